// File: rtl/score_display_pkg.sv
// Shared constants and helpers for the score display controller.
// Segment order is abcdefg with a in the MSB, and every pattern is active-low.
package score_display_pkg;

   localparam logic [6:0] SEG_0     = 7'b0000001;
   localparam logic [6:0] SEG_1     = 7'b1001111;
   localparam logic [6:0] SEG_2     = 7'b0010010;
   localparam logic [6:0] SEG_3     = 7'b0000110;
   localparam logic [6:0] SEG_4     = 7'b1001100;
   localparam logic [6:0] SEG_5     = 7'b0100100;
   localparam logic [6:0] SEG_6     = 7'b0100000;
   localparam logic [6:0] SEG_7     = 7'b0001111;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0000100;
   localparam logic [6:0] SEG_DASH  = 7'b1111110;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   function automatic logic [6:0] seg_of_digit(input logic [3:0] digit);
      case (digit)
         4'd0:    return SEG_0;
         4'd1:    return SEG_1;
         4'd2:    return SEG_2;
         4'd3:    return SEG_3;
         4'd4:    return SEG_4;
         4'd5:    return SEG_5;
         4'd6:    return SEG_6;
         4'd7:    return SEG_7;
         4'd8:    return SEG_8;
         4'd9:    return SEG_9;
         default: return SEG_DASH;
      endcase
   endfunction

   // The player index needs at least one bit, even when there is a single player.
   function automatic int pid_w(input int numPlayers);
      return (numPlayers <= 1) ? 1 : $clog2(numPlayers);
   endfunction

endpackage

// File: rtl/score_display_ctrl_if.sv
// Connects the game FSM (master) to the score display controller (slave).
interface score_display_ctrl_if #(
   parameter int NUM_PLAYERS = 2,
   parameter int SCORE_W     = 5,
   parameter int STATE_W     = 4
);
   localparam int PID_W = score_display_pkg::pid_w(NUM_PLAYERS);

   logic                        prize_valid;
   logic [PID_W-1:0]            prize_player;
   logic [NUM_PLAYERS*SCORE_W-1:0] score_in;
   logic [STATE_W-1:0]          state;
   logic [NUM_PLAYERS*14-1:0]   hex_out;
   logic [NUM_PLAYERS-1:0]      player_led;
   logic                        final_led;
   logic                        state_led;

   modport master (
      output prize_valid, prize_player, score_in, state,
      input  hex_out, player_led, final_led, state_led
   );

   modport slave (
      input  prize_valid, prize_player, score_in, state,
      output hex_out, player_led, final_led, state_led
   );

endinterface

// File: rtl/score_display_ctrl_seg7_encoder.sv
// Turns one player's score into two active-low digits, tens then units.
// When LEADING_ZERO_BLANK_EN is defined, the tens digit is blank for valid scores below 10.
module seg7_encoder
   import score_display_pkg::*;
#(
   parameter int SCORE_W = 5
) (
   input  logic               valid_i,
   input  logic [SCORE_W-1:0] score_i,
   output logic [13:0]        seg_o
);

   logic       inRange;
   logic [6:0] scoreLow;
   logic [3:0] tens;
   logic [3:0] units;

   // Truncating to 7 bits is safe because scoreLow only feeds the digits when the score is below 100.
   always_comb begin
      inRange  = (32'(score_i) < 32'd100);
      scoreLow = 7'(score_i);
      tens     = 4'(scoreLow / 7'd10);
      units    = 4'(scoreLow % 7'd10);
      if (!valid_i || !inRange) begin
         seg_o = {SEG_DASH, SEG_DASH};
      end else begin
`ifdef LEADING_ZERO_BLANK_EN
         seg_o = {((tens == 4'd0) ? SEG_BLANK : seg_of_digit(tens)), seg_of_digit(units)};
`else
         seg_o = {seg_of_digit(tens), seg_of_digit(units)};
`endif
      end
   end

endmodule

// File: rtl/score_display_ctrl.sv
// Latches each player's score on a prize, then drives the HEX digits and the award, final and activity LEDs.
// Leading-zero blanking is selected by LEADING_ZERO_BLANK_EN through seg7_encoder.
module score_display_ctrl
   import score_display_pkg::*;
#(
   parameter int                  NUM_PLAYERS = 2,
   parameter int                  SCORE_W     = 5,
   parameter int                  STATE_W     = 4,
   parameter logic [STATE_W-1:0]  IDLE_STATE  = '0,
   parameter logic [STATE_W-1:0]  FINAL_STATE = STATE_W'(4),
   parameter int                  BLINK_DIV   = 25000000
) (
   input logic                 clk,
   input logic                 rst_n,
   score_display_ctrl_if.slave bus
);

   localparam int CNT_W = $clog2(BLINK_DIV);
   localparam int HEX_W = NUM_PLAYERS * 14;

   logic [SCORE_W-1:0]     score_q [NUM_PLAYERS];
   logic [SCORE_W-1:0]     score_d [NUM_PLAYERS];
   logic [NUM_PLAYERS-1:0] valid_q, valid_d;
   logic [NUM_PLAYERS-1:0] award_q, award_d;
   logic [NUM_PLAYERS-1:0] ledOut_q, ledOut_d;
   logic [NUM_PLAYERS-1:0] leaders;
   logic [HEX_W-1:0]       hex_q, hexNext;
   logic                   final_q;
   logic                   stateLed_q, stateLed_d;
   logic                   phase_q, phase_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [STATE_W-1:0]     state_q;
   logic [SCORE_W-1:0]     maxScore;
   logic                   stateChange, idleEntry, inFinal, finalEntry, accept;

   // All outputs are encoded from the next-state scores, so the HEX digits and LEDs update one cycle after the prize.
   always_comb begin
      stateChange = (bus.state != state_q);
      idleEntry   = stateChange && (bus.state == IDLE_STATE);
      inFinal     = (bus.state == FINAL_STATE);
      finalEntry  = stateChange && inFinal;
      accept      = bus.prize_valid && (int'(bus.prize_player) < NUM_PLAYERS) && !idleEntry;

      valid_d = idleEntry ? '0 : valid_q;
      award_d = idleEntry ? '0 : award_q;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
         score_d[i] = score_q[i];
         if (accept && (int'(bus.prize_player) == i)) begin
            score_d[i] = bus.score_in[i*SCORE_W +: SCORE_W];
            valid_d[i] = 1'b1;
         end
      end
      if (accept) begin
         for (int i = 0; i < NUM_PLAYERS; i++) begin
            award_d[i] = (int'(bus.prize_player) == i);
         end
      end

      maxScore = '0;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
         if (valid_d[i] && (score_d[i] > maxScore)) begin
            maxScore = score_d[i];
         end
      end
      for (int i = 0; i < NUM_PLAYERS; i++) begin
         leaders[i] = valid_d[i] && (score_d[i] == maxScore);
      end

      // Forcing the phase on at entry makes the leaders light for the first full half-period.
      cnt_d   = cnt_q + CNT_W'(1);
      phase_d = phase_q;
      if (finalEntry) begin
         cnt_d   = '0;
         phase_d = 1'b1;
      end else if (cnt_q == CNT_W'(BLINK_DIV - 1)) begin
         cnt_d   = '0;
         phase_d = ~phase_q;
      end

      ledOut_d = inFinal ? (leaders & {NUM_PLAYERS{phase_d}}) : award_d;

      stateLed_d = stateLed_q;
      if (bus.state == IDLE_STATE) begin
         stateLed_d = 1'b1;
      end else if (stateChange) begin
         stateLed_d = ~stateLed_q;
      end
   end

   for (genvar g = 0; g < NUM_PLAYERS; g++) begin : gEnc
      seg7_encoder #(.SCORE_W(SCORE_W)) uEnc (
         .valid_i (valid_d[g]),
         .score_i (score_d[g]),
         .seg_o   (hexNext[g*14 +: 14])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_PLAYERS; i++) begin
            score_q[i] <= '0;
         end
         valid_q    <= '0;
         award_q    <= '0;
         ledOut_q   <= '0;
         hex_q      <= {NUM_PLAYERS{{SEG_DASH, SEG_DASH}}};
         final_q    <= 1'b0;
         stateLed_q <= 1'b1;
         phase_q    <= 1'b1;
         cnt_q      <= '0;
         state_q    <= IDLE_STATE;
      end else begin
         for (int i = 0; i < NUM_PLAYERS; i++) begin
            score_q[i] <= score_d[i];
         end
         valid_q    <= valid_d;
         award_q    <= award_d;
         ledOut_q   <= ledOut_d;
         hex_q      <= hexNext;
         final_q    <= inFinal;
         stateLed_q <= stateLed_d;
         phase_q    <= phase_d;
         cnt_q      <= cnt_d;
         state_q    <= bus.state;
      end
   end

   assign bus.hex_out    = hex_q;
   assign bus.player_led = ledOut_q;
   assign bus.final_led  = final_q;
   assign bus.state_led  = stateLed_q;

endmodule

// File: tb/tb_score_display_ctrl.sv
// Testbench for score_display_ctrl with three players, 7-bit scores and a blink half-period of four cycles.
// Honours LEADING_ZERO_BLANK_EN when choosing the expected tens digit.
module tb_score_display_ctrl;

   localparam int NP  = 3;
   localparam int SW  = 7;
   localparam int STW = 4;
   localparam int BD  = 4;

   localparam logic [6:0] S0 = 7'b0000001;
   localparam logic [6:0] S1 = 7'b1001111;
   localparam logic [6:0] S2 = 7'b0010010;
   localparam logic [6:0] S3 = 7'b0000110;
   localparam logic [6:0] S4 = 7'b1001100;
   localparam logic [6:0] S5 = 7'b0100100;
   localparam logic [6:0] S7 = 7'b0001111;
   localparam logic [6:0] S9 = 7'b0000100;
   localparam logic [6:0] D  = 7'b1111110;
   localparam logic [6:0] B  = 7'b1111111;
`ifdef LEADING_ZERO_BLANK_EN
   localparam logic [6:0] TZ = B;
`else
   localparam logic [6:0] TZ = S0;
`endif
   localparam logic [41:0] ALLD = {D, D, D, D, D, D};

   typedef struct {
      logic        pv;
      logic [1:0]  pp;
      logic [6:0]  sc;
      logic [3:0]  st;
      logic [41:0] hex;
      logic [2:0]  led;
      logic        fin;
      logic        sled;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   int   errors = 0;
   int   checks = 0;
   vec_t vecs[10];
   vec_t expQ[$];

   always #5 clk = ~clk;

   score_display_ctrl_if #(.NUM_PLAYERS(NP), .SCORE_W(SW), .STATE_W(STW)) bus ();

   score_display_ctrl #(
      .NUM_PLAYERS (NP),
      .SCORE_W     (SW),
      .STATE_W     (STW),
      .IDLE_STATE  (4'd0),
      .FINAL_STATE (4'd4),
      .BLINK_DIV   (BD)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   function automatic vec_t mk(input logic pv, input logic [1:0] pp, input logic [6:0] sc,
                               input logic [3:0] st, input logic [41:0] hex, input logic [2:0] led);
      vec_t v;
      v.pv = pv; v.pp = pp; v.sc = sc; v.st = st;
      v.hex = hex; v.led = led; v.fin = 1'b0; v.sled = 1'b1;
      return v;
   endfunction

   task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Drives one cycle of inputs on the falling edge; score_in puts the score in the addressed slot.
   task automatic drive(input logic pv, input logic [1:0] pp, input logic [6:0] sc, input logic [3:0] st);
      @(negedge clk);
      bus.prize_valid  = pv;
      bus.prize_player = pp;
      bus.score_in     = '0;
      if (pp < 2'd3) bus.score_in[pp*SW +: SW] = sc;
      bus.state        = st;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input vec_t v);
      drive(v.pv, v.pp, v.sc, v.st);
      expQ.push_back(v);
   endtask

   task automatic checkOutput(input int idx);
      vec_t e;
      tick();
      if (expQ.size() == 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL vec%0d.scoreboard: got empty queue, expected one entry", idx);
      end else begin
         e = expQ.pop_front();
         checkVal($sformatf("vec%0d.hex", idx), 64'(bus.hex_out), 64'(e.hex));
         checkVal($sformatf("vec%0d.player_led", idx), 64'(bus.player_led), 64'(e.led));
         checkVal($sformatf("vec%0d.final_led", idx), 64'(bus.final_led), 64'(e.fin));
         checkVal($sformatf("vec%0d.state_led", idx), 64'(bus.state_led), 64'(e.sled));
      end
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int   seqSt[5]  = '{1, 1, 2, 3, 3};
      logic seqExp[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

      bus.prize_valid  = 1'b0;
      bus.prize_player = '0;
      bus.score_in     = '0;
      bus.state        = 4'd0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #2;
      checkVal("reset.hex", 64'(bus.hex_out), 64'(ALLD));
      checkVal("reset.player_led", 64'(bus.player_led), 64'(3'b000));
      checkVal("reset.final_led", 64'(bus.final_led), 64'(1'b0));
      checkVal("reset.state_led", 64'(bus.state_led), 64'(1'b1));
      @(negedge clk);
      rst_n = 1'b1;

      // Hex words are ordered {p2 tens, p2 units, p1 tens, p1 units, p0 tens, p0 units}.
      vecs[0] = mk(1'b0, 2'd0, 7'd0,   4'd0, ALLD,                       3'b000);
      vecs[1] = mk(1'b1, 2'd1, 7'd37,  4'd0, {D, D, S3, S7, D, D},       3'b010);
      vecs[2] = mk(1'b0, 2'd0, 7'd0,   4'd0, {D, D, S3, S7, D, D},       3'b010);
      vecs[3] = mk(1'b1, 2'd0, 7'd5,   4'd0, {D, D, S3, S7, TZ, S5},     3'b001);
      vecs[4] = mk(1'b1, 2'd2, 7'd100, 4'd0, {D, D, S3, S7, TZ, S5},     3'b100);
      vecs[5] = mk(1'b1, 2'd3, 7'd55,  4'd0, {D, D, S3, S7, TZ, S5},     3'b100);
      vecs[6] = mk(1'b1, 2'd2, 7'd0,   4'd0, {TZ, S0, S3, S7, TZ, S5},   3'b100);
      vecs[7] = mk(1'b1, 2'd2, 7'd99,  4'd0, {S9, S9, S3, S7, TZ, S5},   3'b100);
      vecs[8] = mk(1'b1, 2'd0, 7'd127, 4'd0, {S9, S9, S3, S7, D, D},     3'b001);
      vecs[9] = mk(1'b1, 2'd0, 7'd10,  4'd0, {S9, S9, S3, S7, S1, S0},   3'b001);
      for (int i = 0; i < 10; i++) begin
         applyStimulus(vecs[i]);
         checkOutput(i);
      end

      // Leaders tie at 40, so players 1 and 2 blink four cycles on, four off.
      drive(1'b1, 2'd0, 7'd12, 4'd0); tick();
      drive(1'b1, 2'd1, 7'd40, 4'd0); tick();
      drive(1'b1, 2'd2, 7'd40, 4'd0); tick();
      checkVal("setup.player_led", 64'(bus.player_led), 64'(3'b100));
      checkVal("setup.p1_hex", 64'(bus.hex_out[27:14]), 64'({S4, S0}));
      drive(1'b0, 2'd0, 7'd0, 4'd2); tick();
      drive(1'b0, 2'd0, 7'd0, 4'd4);
      for (int k = 0; k < 12; k++) begin
         tick();
         checkVal($sformatf("blink%0d.player_led", k), 64'(bus.player_led),
                  64'((((k / 4) % 2) == 0) ? 3'b110 : 3'b000));
         checkVal($sformatf("blink%0d.final_led", k), 64'(bus.final_led), 64'(1'b1));
      end
      drive(1'b0, 2'd0, 7'd0, 4'd3); tick();
      checkVal("leave_final.final_led", 64'(bus.final_led), 64'(1'b0));
      checkVal("leave_final.player_led", 64'(bus.player_led), 64'(3'b100));

      drive(1'b0, 2'd0, 7'd0, 4'd0); tick();
      checkVal("new_game.hex", 64'(bus.hex_out), 64'(ALLD));
      checkVal("new_game.player_led", 64'(bus.player_led), 64'(3'b000));
      checkVal("new_game.state_led", 64'(bus.state_led), 64'(1'b1));

      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 2'd0, 7'd0, 4'(seqSt[i])); tick();
         checkVal($sformatf("state_seq%0d.state_led", i), 64'(bus.state_led), 64'(seqExp[i]));
      end

      drive(1'b1, 2'd1, 7'd22, 4'd0); tick();
      checkVal("collision.p1_hex", 64'(bus.hex_out[27:14]), 64'({D, D}));
      checkVal("collision.player_led", 64'(bus.player_led), 64'(3'b000));
      checkVal("collision.state_led", 64'(bus.state_led), 64'(1'b1));
      drive(1'b0, 2'd0, 7'd0, 4'd0); tick();
      checkVal("collision_after.hex", 64'(bus.hex_out), 64'(ALLD));

      drive(1'b1, 2'd0, 7'd12, 4'd1); tick();
      checkVal("pre_reset.p0_hex", 64'(bus.hex_out[13:0]), 64'({S1, S2}));
      checkVal("pre_reset.player_led", 64'(bus.player_led), 64'(3'b001));
      drive(1'b0, 2'd0, 7'd0, 4'd4); tick(); tick();
      checkVal("pre_reset.final_led", 64'(bus.final_led), 64'(1'b1));
      checkVal("pre_reset.blink_led", 64'(bus.player_led), 64'(3'b001));
      #2 rst_n = 1'b0;
      #1;
      checkVal("async_reset.hex", 64'(bus.hex_out), 64'(ALLD));
      checkVal("async_reset.player_led", 64'(bus.player_led), 64'(3'b000));
      checkVal("async_reset.final_led", 64'(bus.final_led), 64'(1'b0));
      checkVal("async_reset.state_led", 64'(bus.state_led), 64'(1'b1));
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/score_display_ctrl.md
Name: score_display_ctrl

Overview:
- Parametrised successor to the two-player score/prize display driver for the game FSM.
- Registers per-player scores on prize events and encodes them as two decimal digits on active-low 7-segment outputs.
- Drives per-player award LEDs, which blink for the leader(s) in the final state, plus a state-activity LED and a final-state LED.
- Sits between the game FSM and board HEX/LED pins.

Parameters:
- NUM_PLAYERS, 2, number of players (1..8).
- SCORE_W, 5, width of each player's score field.
- STATE_W, 4, width of the FSM state code.
- IDLE_STATE, 4'd0, state code for idle/new game.
- FINAL_STATE, 4'd4, state code for game over.
- BLINK_DIV, 25000000, clock cycles per blink half-period (>=2).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- prize_valid  in  1  one-cycle strobe: a prize was awarded
- prize_player  in  PID_W=max(1,$clog2(NUM_PLAYERS))  index of the awarded player
- score_in  in  NUM_PLAYERS*SCORE_W  packed scores; player i is at [i*SCORE_W +: SCORE_W]
- state  in  STATE_W  current FSM state code
- hex_out  out  NUM_PLAYERS*14  player i is at [i*14 +: 14]; upper 7 bits = tens, lower 7 bits = units; segment order abcdefg, MSB=a, active-low
- player_led  out  NUM_PLAYERS  award/leader LEDs
- final_led  out  1  high while in FINAL_STATE
- state_led  out  1  activity LED

Behaviour:
- Clock and reset: one clock domain (clk); rst_n is asynchronous and active-low. All outputs are registered.
- Reset values:
  - hex_out = all DASH (7'b1111110 per digit).
  - player_led = 0, final_led = 0, state_led = 1.
  - Latched scores cleared; all valid flags = 0; blink counter = 0; blink phase = 1; state_q = IDLE_STATE.
- Prize latch:
  - On prize_valid with prize_player < NUM_PLAYERS: latch that player's score_in slice and set its valid flag.
  - prize_player >= NUM_PLAYERS: the strobe is ignored entirely.
- Digit encoding:
  - hex_out reflects the latched value 1 cycle after prize_valid.
  - Valid score 0..99: tens = score/10, units = score%10; "00" is legal.
  - Score >= 100 (only possible when SCORE_W >= 7): both digits DASH.
  - Invalid (never awarded): both digits DASH.
- Award LED:
  - On an accepted prize, player_led becomes one-hot on the awarded player (1-cycle latency).
  - The LED holds until the next accepted prize or until IDLE.
- Final state:
  - final_led = 1 one cycle after state == FINAL_STATE, 0 one cycle after leaving it.
  - While in FINAL_STATE, player_led[i] = blink phase for every valid player whose latched score equals the maximum valid score (ties: all tied players blink); all other LEDs are 0.
- Blink counter:
  - Counts 0..BLINK_DIV-1; the blink phase toggles on wrap.
  - On entry to FINAL_STATE (state != state_q and state == FINAL_STATE), the counter is forced to 0 and the phase to 1, so the LED is ON for the first BLINK_DIV cycles.
- State LED:
  - state_q registers state every cycle.
  - When state == IDLE_STATE, state_led = 1.
  - Otherwise state_led toggles in the cycle after any change (state != state_q); it holds if the state is unchanged.
- New game: on entering IDLE_STATE from any other state, clear all valid flags, set hex_out to DASH and player_led to 0.
- Simultaneous events:
  - If the IDLE entry clear coincides with prize_valid, the clear wins and the prize is dropped.
  - A prize in FINAL_STATE still updates the score and leader computation; the one-hot award LED is suppressed in favour of the blink display.
- Reset mid-operation: immediate return to the reset values regardless of counter phase.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: the tens digit is BLANK (7'b1111111) when a valid score is < 10.
- Undefined: the tens digit shows "0".
- DASH behaviour is unchanged in both cases.

Decomposition:
- Package score_display_pkg:
  - Segment constants SEG_0..SEG_9, SEG_DASH, SEG_BLANK.
  - Function seg_of_digit(4-bit) returning SEG_DASH for values > 9.
  - PID_W helper.
- Sub-module seg7_encoder: combinational, valid + SCORE_W score in -> 14-bit tens/units segments. Handles the >=100 and invalid cases and LEADING_ZERO_BLANK_EN. Instantiated NUM_PLAYERS times via generate.

Test Plan (bench uses BLINK_DIV = 4, NUM_PLAYERS = 3, SCORE_W = 7):
- Reset: rst_n low -> every hex digit = 7'b1111110, player_led = 0, state_led = 1, final_led = 0.
- Prize, two digits: score_in[1] = 37, prize_valid with prize_player = 1 -> next cycle player 1 tens = SEG_3 (0000110), units = SEG_7 (0001111), player_led = 3'b010; players 0 and 2 still DASH.
- Boundary scores: score 5 -> tens SEG_0 (SEG_BLANK with LEADING_ZERO_BLANK_EN), units SEG_5; score 100 -> both digits DASH; prize_player = 3 -> no change.
- Final-state blink: latch scores 12/40/40, state 2 -> 4 -> final_led = 1; player_led = 3'b110 for 4 cycles, 3'b000 for 4 cycles, repeating.
- State LED: state sequence 1, 1, 2, 3, 3 -> state_led toggles exactly twice after the initial change out of idle; returning to state 0 -> state_led = 1 and all hex digits DASH next cycle.
- Clear collision and async reset: state enters IDLE on the same cycle as prize_valid -> player stays DASH. Asserting rst_n low mid-blink, off any clock edge -> outputs reach reset values without waiting for a clock.
